// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard/sequencing controller (optional PIPE_FORWARDING_EN)
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             m_ex1, m_ex2, m_mem1, m_mem2;
  logic             hazard, mwait;

  // Register x0 is hardwired zero, so it never creates a dependency.
  assign m_ex1  = id_use_rs1 & ex_we  & (ex_rd  != '0) & (ex_rd  == id_rs1);
  assign m_ex2  = id_use_rs2 & ex_we  & (ex_rd  != '0) & (ex_rd  == id_rs2);
  assign m_mem1 = id_use_rs1 & mem_we & (mem_rd != '0) & (mem_rd == id_rs1);
  assign m_mem2 = id_use_rs2 & mem_we & (mem_rd != '0) & (mem_rd == id_rs2);
  assign mwait  = mem_req & ~mem_ready;

`ifdef PIPE_FORWARDING_EN
  assign hazard = (m_ex1 | m_ex2) & ex_is_load;
`else
  // Full interlock; the load term is subsumed by the plain EX match.
  assign hazard = m_ex1 | m_ex2 | m_mem1 | m_mem2 | ((m_ex1 | m_ex2) & ex_is_load);
`endif

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (mwait) begin
          state_d = MEM_WAIT;
        end else if (ex_branch_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hazard) begin
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          // A branch still sitting in EX must not slip through unflushed.
          ifid_flush = ex_branch_taken;
          idex_flush = ex_branch_taken;
          state_d    = RUN;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= INIT;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!pc_en && state_q != INIT && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_FORWARDING_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  always_comb begin
    fwd_a_d = m_ex1 ? 2'b10 : (m_mem1 ? 2'b01 : 2'b00);
    fwd_b_d = m_ex2 ? 2'b10 : (m_mem2 ? 2'b01 : 2'b00);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (idex_en) begin
      fwd_a_q <= idex_flush ? 2'b00 : fwd_a_d;
      fwd_b_q <= idex_flush ? 2'b00 : fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_use_rs1, id_use_rs2, ex_we, ex_is_load, mem_we;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt;

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] en;
    logic [1:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [3:0] ecnt = 4'd0;

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LU = 5'b00111;

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_we = 0; ex_is_load = 0; mem_rd = '0; mem_we = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic bump();
    if (ecnt != 4'hF) ecnt = ecnt + 4'd1;
  endtask

  // Push expectation with the stimulus, pop and compare once outputs settle.
  task automatic cyc(input string tag, input logic [4:0] en, input logic [1:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    exp_q.push_back('{en: en, fl: fl, fa: fa, fb: fb, cnt: ecnt});
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    assert ({pc_en, ifid_en, idex_en, exmem_en, memwb_en} === e.en) else begin
      n_fail++; $error("FAIL %s enables observed=%b expected=%b", tag,
                       {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
    end
    n_cmp++;
    assert ({ifid_flush, idex_flush} === e.fl) else begin
      n_fail++; $error("FAIL %s flushes observed=%b expected=%b", tag, {ifid_flush, idex_flush}, e.fl);
    end
    n_cmp++;
    assert ({fwd_a, fwd_b} === {e.fa, e.fb}) else begin
      n_fail++; $error("FAIL %s fwd observed=%b/%b expected=%b/%b", tag, fwd_a, fwd_b, e.fa, e.fb);
    end
    n_cmp++;
    assert (stall_cnt === e.cnt) else begin
      n_fail++; $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, e.cnt);
    end
    @(negedge Clk);
  endtask

  initial begin
    clear_in();
    Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    cyc("reset", NONE, 2'b11, 2'b00, 2'b00);
    Rst_n = 1'b1;
    cyc("init", NONE, 2'b11, 2'b00, 2'b00);
    cyc("run_idle", ALL, 2'b00, 2'b00, 2'b00);

    // Load-use on rs1
    ex_is_load = 1; ex_we = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    cyc("load_use", LU, 2'b01, 2'b00, 2'b00);
    bump();
    ex_is_load = 0; ex_we = 0; ex_rd = '0; mem_we = 1; mem_rd = 5'd5;
    if (FWD) begin
      cyc("load_in_mem", ALL, 2'b00, 2'b00, 2'b00);
      clear_in();
      cyc("fwd_a_mem", ALL, 2'b00, 2'b01, 2'b00);
    end else begin
      cyc("load_in_mem", LU, 2'b01, 2'b00, 2'b00);
      bump();
      clear_in();
      cyc("fwd_a_mem", ALL, 2'b00, 2'b00, 2'b00);
    end

    // Non-load EX producer on rs2, then freeze to check fwd hold
    ex_we = 1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1;
    if (FWD) begin
      cyc("fwd_ex", ALL, 2'b00, 2'b00, 2'b00);
    end else begin
      cyc("fwd_ex", LU, 2'b01, 2'b00, 2'b00);
      bump();
    end
    clear_in(); mem_req = 1;
    cyc("fwd_hold_wait", NONE, 2'b00, 2'b00, FWD ? 2'b10 : 2'b00);
    bump();
    mem_ready = 1;
    cyc("fwd_hold_rel", ALL, 2'b00, 2'b00, FWD ? 2'b10 : 2'b00);

    // x0 destination never matches, even for a load
    clear_in(); ex_we = 1; ex_is_load = 1; id_use_rs1 = 1;
    cyc("x0_nomatch", ALL, 2'b00, 2'b00, 2'b00);

    // Memory wait: 4 frozen cycles then release
    clear_in(); mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      cyc("mem_wait", NONE, 2'b00, 2'b00, 2'b00);
      bump();
    end
    mem_ready = 1;
    cyc("mem_release", ALL, 2'b00, 2'b00, 2'b00);

    // Branch beats load-use
    clear_in();
    ex_is_load = 1; ex_we = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1; ex_branch_taken = 1;
    cyc("branch_vs_lu", ALL, 2'b11, 2'b00, 2'b00);

    // Freeze beats branch; release with branch applies flush
    clear_in(); ex_branch_taken = 1; mem_req = 1;
    cyc("mwait_branch", NONE, 2'b00, 2'b00, 2'b00);
    bump();
    cyc("wait_branch", NONE, 2'b00, 2'b00, 2'b00);
    bump();
    mem_ready = 1;
    cyc("rel_branch", ALL, 2'b11, 2'b00, 2'b00);

    // Saturation at 15, then asynchronous reset mid-wait
    clear_in(); mem_req = 1;
    for (int i = 0; i < 20; i++) begin
      cyc("saturate", NONE, 2'b00, 2'b00, 2'b00);
      bump();
    end
    n_cmp++;
    assert (ecnt === 4'hF && stall_cnt === 4'hF) else begin
      n_fail++; $error("FAIL sat_final stall_cnt observed=%0d expected=15", stall_cnt);
    end
    Rst_n = 1'b0;
    ecnt = 4'd0;
    cyc("async_reset", NONE, 2'b11, 2'b00, 2'b00);
    clear_in();
    Rst_n = 1'b1;
    cyc("init2", NONE, 2'b11, 2'b00, 2'b00);
    cyc("run2", ALL, 2'b00, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
